// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for one synchronous-read data-memory port.
// Owners hand over after MAX_HOLD transfers when contended; read data returns one cycle later, routed by tag.
module dmem_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int            CW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    state_t        w_oth_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_fav1;       // 1: an IDLE tie goes to r1
    logic          w_fav1_nxt;
    logic          r_rd_valid;
    logic          r_rd_tag;     // 1: pending read belongs to r1
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_acc;
    logic          w_own_is_r0;
    logic          w_own_req;
    logic          w_oth_req;

    assign w_gnt0      = (r_state == OWN0) && r0_req;
    assign w_gnt1      = (r_state == OWN1) && r1_req;
    assign w_acc       = w_gnt0 | w_gnt1;
    assign w_own_is_r0 = (r_state == OWN0);
    assign w_own_req   = w_own_is_r0 ? r0_req : r1_req;
    assign w_oth_req   = w_own_is_r0 ? r1_req : r0_req;
    assign w_oth_state = w_own_is_r0 ? OWN1 : OWN0;

    assign r0_gnt = w_gnt0;
    assign r1_gnt = w_gnt1;

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fav1_nxt  = r_fav1;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (r0_req && r1_req)
                    w_state_nxt = r_fav1 ? OWN1 : OWN0;
                else if (r0_req)
                    w_state_nxt = OWN0;
                else if (r1_req)
                    w_state_nxt = OWN1;
            end
            OWN0, OWN1: begin
                if (!w_own_req) begin
                    w_cnt_nxt   = '0;
                    w_fav1_nxt  = w_own_is_r0;
                    w_state_nxt = w_oth_req ? w_oth_state : IDLE;
                end else if (r_cnt == HOLD_LAST) begin
                    // Quota used up: yield only if the other side is actually waiting.
                    w_cnt_nxt = '0;
                    if (w_oth_req) begin
                        w_state_nxt = w_oth_state;
                        w_fav1_nxt  = w_own_is_r0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt0) begin
            mem_we    = r0_we;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
        end else if (w_gnt1) begin
            mem_we    = r1_we;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_fav1     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_tag   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_fav1     <= w_fav1_nxt;
            r_rd_valid <= w_acc && !mem_we;
            r_rd_tag   <= w_gnt1;
        end
    end

    // The return path is independent of ownership, so a read issued on a hand-over edge still comes back.
    assign r0_rvalid = r_rd_valid && !r_rd_tag;
    assign r1_rvalid = r_rd_valid && r_rd_tag;
    assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
    assign r1_rdata  = r1_rvalid ? mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DW, default 32: data width.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter MAX_HOLD, default 4: maximum consecutive accepted transfers per owner while the other requester waits.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 r0_req, r0_we  input  1 each  core data-port request and write enable.
REQ-007 r0_addr  input  AW; r0_wdata  input  DW  core address and store data.
REQ-008 r0_gnt, r0_rvalid  output  1 each; r0_rdata  output  DW  core grant, read-data valid and read data.
REQ-009 r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same directions and widths as the r0_* ports, for the second requester (DMA/peripheral).
REQ-010 mem_we  output  1; mem_addr  output  AW; mem_wdata  output  DW  single shared data-memory port.
REQ-011 mem_rdata  input  DW  memory read data, valid one cycle after the address is presented (synchronous read).

Function
REQ-012 FSM states: IDLE, OWN0, OWN1, held in a register; rx_gnt = 1 only in OWNx while rx_req = 1.
REQ-013 An accepted transfer is a cycle with rx_gnt = 1; the memory port SHALL carry the owner's we/addr/wdata combinationally in that cycle.
REQ-014 With no accepted transfer: mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-015 IDLE -> OWN0 or OWN1 on the next edge when any req = 1; grant latency from IDLE is exactly 1 cycle.
REQ-016 Tie in IDLE: a 1-bit last-owner pointer grants the requester NOT served most recently; after reset the pointer favours r0.
REQ-017 OWNx with rx_req = 0: go to OWNy if ry_req = 1 (no idle bubble), else IDLE.
REQ-018 Hold counter counts accepted transfers of the current owner; it clears on every ownership change and on entry to IDLE.
REQ-019 When the count reaches MAX_HOLD while the other requester's req = 1, ownership moves to the other requester on the next edge, even if the owner still requests.
REQ-020 When the count reaches MAX_HOLD and the other req = 0, the counter clears and the owner keeps the grant.
REQ-021 The last-owner pointer updates on every transition out of OWNx.
REQ-022 Read return: an accepted read (we = 0) registers a valid bit and requester tag; on the following cycle that requester's rvalid = 1 and rdata = mem_rdata. The other rvalid = 0, and that rdata = 0.
REQ-023 Read returns SHALL be delivered even if ownership changed on the same edge; back-to-back reads from either requester return one per cycle in order.
REQ-024 Writes produce no rvalid.
REQ-025 rx_gnt never asserts for both requesters in the same cycle.
REQ-026 req deasserted while granted: no memory access that cycle; already-issued reads still return.

Reset
REQ-027 While reset = 0: state = IDLE, hold counter = 0, pointer favours r0, pending read valid = 0, and all outputs = 0. This applies asynchronously, including mid-transfer.
REQ-028 A read accepted in the cycle reset asserts SHALL NOT produce rvalid after reset releases.
REQ-029 The first arbitration edge is the first rising clk with reset = 1.

Verification
REQ-030 Single read: r0_req = 1, r0_we = 0, r0_addr = 0x10 from IDLE -> r0_gnt = 1 the next cycle with mem_addr = 0x10. The cycle after, r0_rvalid = 1 and r0_rdata = memory word at 0x10.
REQ-031 Simultaneous req from IDLE after reset -> r0 granted first. When r0 drops, r1 is granted with no bubble. The next tie favours r0 only if r1 was the last owner.
REQ-032 Fairness, MAX_HOLD = 4: r0 and r1 both requesting continuously -> grants alternate in blocks of exactly 4 accepted transfers: r0×4, r1×4, r0×4.
REQ-033 Solo owner: only r1 requests for 10 cycles -> r1_gnt stays 1 for all 10 cycles; the counter wraps silently.
REQ-034 Read across switch: r0's 4th read at address 0x20 on the switch edge, then r1 writes 0x55 to 0x24 -> r0_rvalid = 1 with the 0x20 data in the cycle r1's write is accepted; r1_rvalid stays 0.
REQ-035 Reset mid-read: reset = 0 asynchronously in the cycle after an r1 read is accepted -> r1_rvalid and all grants drop to 0 immediately and stay 0 until a new request after release.
